// File: rtl/spi_pkg.sv
// Shared definitions for the SPI flash read sequencer: opcodes, controller mode and FSM states.
package spi_pkg;

    localparam logic [2:0] SPI_MODE_SINGLE = 3'd0;
    localparam logic [7:0] OPC_READ        = 8'h03;
    localparam logic [7:0] OPC_FAST_READ   = 8'h0B;

    typedef enum logic [2:0] {
        ST_CS_GAP,
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA
    } seq_state_e;

    // Address goes out MSB first: index 0 is bits 23:16.
    function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
        case (idx)
            2'd0:    return addr[23:16];
            2'd1:    return addr[15:8];
            default: return addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_read_seq_if.sv
// Request and read-data stream bundle between the upstream boot/prefetch logic and the sequencer.
interface spi_flash_read_seq_if;

    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    modport master (
        output req_valid, req_addr, req_len, out_ready,
        input  req_ready, out_valid, out_data
    );

    modport slave (
        input  req_valid, req_addr, req_len, out_ready,
        output req_ready, out_valid, out_data
    );

endinterface

// File: rtl/spi_flash_read_seq_fifo.sv
// Small synchronous FIFO buffering received flash bytes ahead of the valid/ready output port.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A pop frees its slot first, so a push into a full FIFO is accepted in the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CAP) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CAP);
    assign empty = (count_q == '0);
    assign level = count_q;

endmodule

// File: rtl/spi_flash_read_seq.sv
// Hardware read sequencer: frames chip select, issues READ/FAST_READ + address through the
// spi_controller byte interface and streams the received bytes out with backpressure.
module spi_flash_read_seq
    import spi_pkg::*;
#(
    parameter int FAST_READ   = 0,
    parameter int DUMMY_BYTES = 1,
    parameter int CS_HIGH_MIN = 4,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spi_flash_read_seq_if.slave   bus,
    input  logic                  abort,
    output logic                  done,
    output logic                  spi_cs,
    output logic [2:0]            spi_mode,
    output logic [7:0]            spi_byte_tx,
    output logic                  spi_byte_tx_strobe,
    input  logic [7:0]            spi_byte_rx,
    input  logic                  spi_idle
);

    localparam int GW = (CS_HIGH_MIN > 1) ? $clog2(CS_HIGH_MIN) : 1;
    localparam logic [GW-1:0] GAP_LAST   = GW'(CS_HIGH_MIN - 1);
    localparam logic [2:0]    DUMMY_LAST = 3'(DUMMY_BYTES - 1);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] FIFO_CAP   = LW'(FIFO_DEPTH);

    seq_state_e  state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic        busy_q, busy_d;
    logic        skip_q, skip_d;
    logic        abort_q, abort_d;
    logic        cs_q, cs_d;
    logic        strobe_q, strobe_d;
    logic [7:0]  tx_q, tx_d;
    logic        done_q, done_d;
    logic        req_ready_q, req_ready_d;

    logic        fifo_push, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [LW-1:0] fifo_level;
    logic        abort_pend, byte_done, end_txn;
    logic [7:0]  tx_byte;

    always_comb begin
        case (state_q)
            ST_CMD:  tx_byte = (FAST_READ != 0) ? OPC_FAST_READ : OPC_READ;
            ST_ADDR: tx_byte = addr_byte(addr_q, byte_cnt_q[1:0]);
            default: tx_byte = 8'h00;
        endcase
    end

    // The controller needs a cycle to drop spi_idle after a strobe, so idle is not trusted
    // during the strobe cycle or the one after it.
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        skip_d      = strobe_q;
        abort_d     = abort_q;
        cs_d        = cs_q;
        strobe_d    = 1'b0;
        tx_d        = tx_q;
        done_d      = 1'b0;
        req_ready_d = 1'b0;
        fifo_push   = 1'b0;
        end_txn     = 1'b0;
        abort_pend  = abort_q | abort;
        byte_done   = busy_q & ~strobe_q & ~skip_q & spi_idle;

        case (state_q)
            ST_CS_GAP: begin
                cs_d    = 1'b1;
                abort_d = 1'b0;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d   = '0;
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                req_ready_d = 1'b1;
                abort_d     = 1'b0;
                if (bus.req_valid && req_ready_q) begin
                    addr_d      = bus.req_addr;
                    remaining_d = bus.req_len;
                    if (bus.req_len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_CMD;
                        cs_d        = 1'b0;
                        req_ready_d = 1'b0;
                        byte_cnt_d  = '0;
                    end
                end
            end
            default: begin
                abort_d = abort_pend;
                if (busy_q) begin
                    if (byte_done) begin
                        busy_d = 1'b0;
                        if (abort_pend) begin
                            end_txn = 1'b1;
                        end else begin
                            case (state_q)
                                ST_CMD: begin
                                    state_d    = ST_ADDR;
                                    byte_cnt_d = '0;
                                end
                                ST_ADDR: begin
                                    if (byte_cnt_q == 3'd2) begin
                                        state_d    = (FAST_READ != 0) ? ST_DUMMY : ST_DATA;
                                        byte_cnt_d = '0;
                                    end else begin
                                        byte_cnt_d = byte_cnt_q + 3'd1;
                                    end
                                end
                                ST_DUMMY: begin
                                    if (byte_cnt_q == DUMMY_LAST) begin
                                        state_d    = ST_DATA;
                                        byte_cnt_d = '0;
                                    end else begin
                                        byte_cnt_d = byte_cnt_q + 3'd1;
                                    end
                                end
                                default: begin
                                    fifo_push = !fifo_full || bus.out_ready;
                                    if (remaining_q != 16'd0) begin
                                        remaining_d = remaining_q - 16'd1;
                                    end
                                    if (remaining_q <= 16'd1) begin
                                        end_txn = 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end else if (abort_pend) begin
                    end_txn = 1'b1;
                end else if (spi_idle && ((state_q != ST_DATA) || (fifo_level < FIFO_CAP))) begin
                    strobe_d = 1'b1;
                    busy_d   = 1'b1;
                    tx_d     = tx_byte;
                end
                if (end_txn) begin
                    state_d   = ST_CS_GAP;
                    cs_d      = 1'b1;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    abort_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CS_GAP;
            gap_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            skip_q      <= 1'b0;
            abort_q     <= 1'b0;
            cs_q        <= 1'b1;
            strobe_q    <= 1'b0;
            tx_q        <= '0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            skip_q      <= skip_d;
            abort_q     <= abort_d;
            cs_q        <= cs_d;
            strobe_q    <= strobe_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
            req_ready_q <= req_ready_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wdata   (spi_byte_rx),
        .pop     (bus.out_ready),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign bus.req_ready      = req_ready_q;
    assign bus.out_valid      = !fifo_empty;
    assign bus.out_data       = fifo_rdata;
    assign done               = done_q;
    assign spi_cs             = cs_q;
    assign spi_mode           = SPI_MODE_SINGLE;
    assign spi_byte_tx        = tx_q;
    assign spi_byte_tx_strobe = strobe_q;

endmodule
